pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/pipe_sat_counter.sv | 20 ++
 rtl/pipe_stage_reg.sv | 86 ++++++++
 tb/tb_pipe_stage_reg.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants: icodes, stat codes, payload layout, bubble payload
package pipe_pkg;

  // Instruction codes
  localparam logic [3:0] IHALT = 4'h0;
  localparam logic [3:0] INOP  = 4'h1;

  // Status codes
  localparam logic [2:0] SAOK  = 3'h1;

  // Register id meaning "no register"
  localparam logic [3:0] RNONE = 4'hF;

  // Payload layout {cnd, valE, valA, dstE, dstM}, MSB to LSB
  localparam int DSTM_OFF = 0;
  localparam int DSTM_W   = 4;
  localparam int DSTE_OFF = 4;
  localparam int DSTE_W   = 4;
  localparam int VALA_OFF = 8;
  localparam int VALA_W   = 64;
  localparam int VALE_OFF = 72;
  localparam int VALE_W   = 64;
  localparam int CND_OFF  = 136;
  localparam int CND_W    = 1;
  localparam int PAYLOAD_W_DEFAULT = CND_OFF + CND_W;

  // A nop carries no destinations; every other field is zero
  localparam logic [PAYLOAD_W_DEFAULT-1:0] BUBBLE_PAYLOAD_DEFAULT =
    {{(PAYLOAD_W_DEFAULT - 8){1'b0}}, RNONE, RNONE};

endpackage

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating event counter with synchronous clear
module pipe_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Clear wins over increment; once at all-ones the count sticks there
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline boundary register with stall/bubble control; PIPE_STAGE_PERF_EN adds counters
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                   PAYLOAD_W      = PAYLOAD_W_DEFAULT,
  parameter logic [3:0]           BUBBLE_ICODE   = INOP,
  parameter logic [2:0]           BUBBLE_STAT    = SAOK,
  parameter logic [PAYLOAD_W-1:0] BUBBLE_PAYLOAD = PAYLOAD_W'(BUBBLE_PAYLOAD_DEFAULT),
  parameter int                   CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 bubble,
  input  logic [2:0]           in_stat,
  input  logic [3:0]           in_icode,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic [2:0]           out_stat,
  output logic [3:0]           out_icode,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 out_valid,
  output logic                 ctl_conflict
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]     cnt_bubble,
  output logic [CNT_W-1:0]     cnt_stall
`endif
);

  // The payload must at least hold dstE/dstM and counters need a bit
  if ((CNT_W < 1) || (PAYLOAD_W < 8)) begin : g_param_check
    $error("pipe_stage_reg: CNT_W must be >= 1 and PAYLOAD_W >= 8");
  end

  // Stage contents: reset, then bubble, then stall (hold), then load
  always_ff @(posedge clk) begin
    if (rst) begin
      out_icode   <= BUBBLE_ICODE;
      out_stat    <= BUBBLE_STAT;
      out_payload <= BUBBLE_PAYLOAD;
      out_valid   <= 1'b0;
    end else if (bubble) begin
      out_icode   <= BUBBLE_ICODE;
      out_stat    <= BUBBLE_STAT;
      out_payload <= BUBBLE_PAYLOAD;
      out_valid   <= 1'b0;
    end else if (!stall) begin
      out_icode   <= in_icode;
      out_stat    <= in_stat;
      out_payload <= in_payload;
      out_valid   <= 1'b1;
    end
  end

  // Sticky flag: control asked for stall and bubble together at least once
  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_conflict <= 1'b0;
    end else if (bubble && stall) begin
      ctl_conflict <= 1'b1;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic bubble_applied;
  logic stall_applied;

  assign bubble_applied = !rst && bubble;
  assign stall_applied  = !rst && !bubble && stall;

  pipe_sat_counter #(.CNT_W(CNT_W)) u_cnt_bubble (
    .clk   (clk),
    .clr   (rst),
    .inc   (bubble_applied),
    .count (cnt_bubble)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_cnt_stall (
    .clk   (clk),
    .clr   (rst),
    .inc   (stall_applied),
    .count (cnt_stall)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg against a behavioural model
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int PW = 137;

  logic          clk = 1'b0;
  logic          rst, stall, bubble;
  logic [2:0]    in_stat;
  logic [3:0]    in_icode;
  logic [PW-1:0] in_payload;
  logic [2:0]    out_stat;
  logic [3:0]    out_icode;
  logic [PW-1:0] out_payload;
  logic          out_valid, ctl_conflict;
  logic [2:0]    s_out_stat;
  logic [3:0]    s_out_icode;
  logic [PW-1:0] s_out_payload;
  logic          s_out_valid, s_ctl_conflict;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   cnt_bubble, cnt_stall;
  logic [2:0]    s_cnt_bubble, s_cnt_stall;
`endif

  always #5 clk = ~clk;

  pipe_stage_reg #(.PAYLOAD_W(PW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .bubble(bubble),
    .in_stat(in_stat), .in_icode(in_icode), .in_payload(in_payload),
    .out_stat(out_stat), .out_icode(out_icode), .out_payload(out_payload),
    .out_valid(out_valid), .ctl_conflict(ctl_conflict)
`ifdef PIPE_STAGE_PERF_EN
    , .cnt_bubble(cnt_bubble), .cnt_stall(cnt_stall)
`endif
  );

  pipe_stage_reg #(.PAYLOAD_W(PW), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall), .bubble(bubble),
    .in_stat(in_stat), .in_icode(in_icode), .in_payload(in_payload),
    .out_stat(s_out_stat), .out_icode(s_out_icode), .out_payload(s_out_payload),
    .out_valid(s_out_valid), .ctl_conflict(s_ctl_conflict)
`ifdef PIPE_STAGE_PERF_EN
    , .cnt_bubble(s_cnt_bubble), .cnt_stall(s_cnt_stall)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: what the stage must hold after each edge
  logic [3:0]    m_icode;
  logic [2:0]    m_stat;
  logic [PW-1:0] m_payload;
  logic          m_valid, m_conf;
  longint        m_cb, m_cs, m_cb3, m_cs3;
  bit            m_ok = 1'b0;

  function automatic longint sat_inc(input longint v, input int width);
    longint top;
    top = (longint'(1) << width) - 1;
    return (v + 1 > top) ? top : v + 1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_icode = 4'h1; m_stat = 3'h1; m_payload = '0; m_payload[7:0] = 8'hFF;
      m_valid = 1'b0; m_conf = 1'b0;
      m_cb = 0; m_cs = 0; m_cb3 = 0; m_cs3 = 0;
      m_ok = 1'b1;
    end else if (bubble) begin
      m_icode = 4'h1; m_stat = 3'h1; m_payload = '0; m_payload[7:0] = 8'hFF;
      m_valid = 1'b0;
      if (stall) m_conf = 1'b1;
      m_cb  = sat_inc(m_cb, 32);
      m_cb3 = sat_inc(m_cb3, 3);
    end else if (stall) begin
      m_cs  = sat_inc(m_cs, 32);
      m_cs3 = sat_inc(m_cs3, 3);
    end else begin
      m_icode = in_icode; m_stat = in_stat; m_payload = in_payload; m_valid = 1'b1;
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (m_ok) begin
      chk("icode",    out_icode,    m_icode);
      chk("stat",     out_stat,     m_stat);
      chk("payload",  out_payload,  m_payload);
      chk("valid",    out_valid,    m_valid);
      chk("conflict", ctl_conflict, m_conf);
      chk("s_icode",  s_out_icode,  m_icode);
      chk("s_valid",  s_out_valid,  m_valid);
`ifdef PIPE_STAGE_PERF_EN
      chk("cnt_bubble",   cnt_bubble,   m_cb[31:0]);
      chk("cnt_stall",    cnt_stall,    m_cs[31:0]);
      chk("s_cnt_bubble", s_cnt_bubble, m_cb3[2:0]);
      chk("s_cnt_stall",  s_cnt_stall,  m_cs3[2:0]);
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b1; bubble = 1'b0;
    in_icode = 4'hA; in_stat = 3'h4; in_payload = '1;
    tick();
    rst = 1'b0; stall = 1'b0;

    // Reset state with stall held high
    chk("rst_icode",   out_icode, 4'h1);
    chk("rst_stat",    out_stat, 3'h1);
    chk("rst_dst",     out_payload[7:0], 8'hFF);
    chk("rst_upper",   out_payload[PW-1:8], '0);
    chk("rst_valid",   out_valid, 1'b0);
    chk("rst_conflict", ctl_conflict, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
    chk("rst_cnt_bubble", cnt_bubble, 32'd0);
    chk("rst_cnt_stall",  cnt_stall, 32'd0);
`endif

    // Load with one-cycle latency
    in_icode = 4'h6; in_stat = 3'h1;
    in_payload = '0; in_payload[VALE_OFF +: VALE_W] = 64'h1234;
    tick();
    chk("load_icode", out_icode, 4'h6);
    chk("load_valE",  out_payload[VALE_OFF +: VALE_W], 64'h1234);
    chk("load_valid", out_valid, 1'b1);
    in_icode = 4'h7;
    tick();
    chk("load2_icode", out_icode, 4'h7);

    // Stall for three cycles while inputs move
    in_icode = 4'h5;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_icode = 4'(i + 8);
      in_payload = {$urandom, $urandom, $urandom, $urandom, $urandom};
      tick();
      chk("stall_icode", out_icode, 4'h5);
    end
    stall = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_cnt", cnt_stall, 32'd3);
`endif
    in_icode = 4'h2;
    tick();

    // Stall and bubble together
    stall = 1'b1; bubble = 1'b1;
    tick();
    stall = 1'b0; bubble = 1'b0;
    chk("conf_icode", out_icode, 4'h1);
    chk("conf_valid", out_valid, 1'b0);
    chk("conf_flag",  ctl_conflict, 1'b1);
`ifdef PIPE_STAGE_PERF_EN
    chk("conf_cnt_bubble", cnt_bubble, 32'd1);
`endif
    for (int i = 0; i < 10; i++) begin
      in_icode = 4'(i);
      in_payload = {$urandom, $urandom, $urandom, $urandom, $urandom};
      in_stat = 3'($urandom);
      tick();
      chk("conf_sticky", ctl_conflict, 1'b1);
    end

    // Reset in the middle of a stall sequence
    stall = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_conflict", ctl_conflict, 1'b0);
    chk("rst_mid_icode",    out_icode, 4'h1);
    chk("rst_mid_valid",    out_valid, 1'b0);
    tick();
    chk("post_rst_hold_valid", out_valid, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
    chk("post_rst_cnt_stall", cnt_stall, 32'd1);
`endif
    stall = 1'b0;
    tick();

    // Nine bubbles: the 3-bit counter must stop at 7
    rst = 1'b1;
    tick();
    rst = 1'b0; bubble = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    bubble = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
    chk("sat_cnt_bubble3", s_cnt_bubble, 3'h7);
    chk("sat_cnt_bubble",  cnt_bubble, 32'd9);
`endif

    // A few random loads, checked by the model only
    for (int i = 0; i < 8; i++) begin
      in_icode = 4'($urandom); in_stat = 3'($urandom);
      in_payload = {$urandom, $urandom, $urandom, $urandom, $urandom};
      stall = ($urandom_range(0, 3) == 0);
      tick();
    end
    stall = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
